// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts one byte per valid/ready handshake and steps the Tx datapath
// through start, data (LSB first), optional parity and 1-2 stop bits. rst_i is async, active-low.
module uart_tx_ctrl #(
  parameter int DATA_SIZE  = 8,
  parameter int CNT_W      = 4,
  parameter int DEF_PERIOD = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic             parity_en_i,
  input  logic             stop2_i,
  input  logic [CNT_W-1:0] bit_period_i,
  input  logic [CNT_W-1:0] sampling_cntr_out_i,
  input  logic [2:0]       bits_cntr_out_i,
  output logic             cntr_rst_o,
  output logic [CNT_W-1:0] sampling_end_val_o,
  output logic             data_bits_incr_o,
  output logic             data_w_en_o,
  output logic [1:0]       select_o,
  output logic             busy_o,
  output logic             tx_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(DATA_SIZE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sev_q, sev_d;
  logic             par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             accept;
  logic             bit_end;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      sev_q   <= CNT_W'(DEF_PERIOD);
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sev_q   <= sev_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
    end
  end

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign tx_ready_o         = rst_i & (state_q == S_IDLE);
  assign accept             = tx_valid_i & tx_ready_o;
  assign data_w_en_o        = accept;
  assign busy_o             = (state_q != S_IDLE);
  assign cntr_rst_o         = (state_q != S_IDLE);
  assign sampling_end_val_o = sev_q;
  assign bit_end            = (state_q != S_IDLE) && (sampling_cntr_out_i == sev_q);

  always_comb begin
    state_d          = state_q;
    sev_d            = sev_q;
    par_d            = par_q;
    stop2_d          = stop2_q;
    select_o         = 2'd1;
    data_bits_incr_o = 1'b0;
    tx_done_o        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          sev_d   = bit_period_i;
          par_d   = parity_en_i;
          stop2_d = stop2_i;
        end
      end
      S_START: begin
        select_o = 2'd0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        select_o = 2'd2;
        if (bit_end) begin
          data_bits_incr_o = 1'b1;
          if (bits_cntr_out_i == LAST_IDX) state_d = par_q ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        select_o = 2'd3;
        if (bit_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (bit_end) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d   = S_IDLE;
            tx_done_o = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          tx_done_o = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (DATA_SIZE 8 and 5) with emulated datapath counters,
// checked each cycle against a frame-schedule model plus literal timing pins.
module tb_uart_tx_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] vld = 2'b00;
  logic par_en = 1'b0, st2 = 1'b0;
  logic [CW-1:0] per = '0;

  logic [CW-1:0] samp8, samp5, sev8, sev5;
  logic [2:0] bcnt8, bcnt5;
  logic rdy8, crst8, incr8, wen8, busy8, done8;
  logic rdy5, crst5, incr5, wen5, busy5, done5;
  logic [1:0] sel8, sel5;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_SIZE(8), .CNT_W(CW), .DEF_PERIOD(15)) u8 (
    .clk_i(clk), .rst_i(rst_n), .tx_valid_i(vld[0]), .tx_ready_o(rdy8),
    .parity_en_i(par_en), .stop2_i(st2), .bit_period_i(per),
    .sampling_cntr_out_i(samp8), .bits_cntr_out_i(bcnt8), .cntr_rst_o(crst8),
    .sampling_end_val_o(sev8), .data_bits_incr_o(incr8), .data_w_en_o(wen8),
    .select_o(sel8), .busy_o(busy8), .tx_done_o(done8));

  uart_tx_ctrl #(.DATA_SIZE(5), .CNT_W(CW), .DEF_PERIOD(15)) u5 (
    .clk_i(clk), .rst_i(rst_n), .tx_valid_i(vld[1]), .tx_ready_o(rdy5),
    .parity_en_i(par_en), .stop2_i(st2), .bit_period_i(per),
    .sampling_cntr_out_i(samp5), .bits_cntr_out_i(bcnt5), .cntr_rst_o(crst5),
    .sampling_end_val_o(sev5), .data_bits_incr_o(incr5), .data_w_en_o(wen5),
    .select_o(sel5), .busy_o(busy5), .tx_done_o(done5));

  // Datapath counters as the real datapath would behave around the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp8 <= '0; samp5 <= '0; bcnt8 <= '0; bcnt5 <= '0;
    end else begin
      samp8 <= !crst8 ? '0 : ((samp8 == sev8) ? '0 : samp8 + 1'b1);
      samp5 <= !crst5 ? '0 : ((samp5 == sev5) ? '0 : samp5 + 1'b1);
      bcnt8 <= !crst8 ? '0 : (incr8 ? bcnt8 + 3'd1 : bcnt8);
      bcnt5 <= !crst5 ? '0 : (incr5 ? bcnt5 + 3'd1 : bcnt5);
    end
  end

  // Frame model: a frame is a list of bits, each (period+1) cycles; m_k counts cycles into it.
  bit            m_act [2];
  int            m_k   [2];
  int            m_p   [2];
  int            m_par [2];
  int            m_st2 [2];
  logic [CW-1:0] m_sev [2];

  function automatic int dsize(input int g);
    return (g == 0) ? 8 : 5;
  endfunction

  function automatic int flen(input int g);
    return (2 + dsize(g) + m_par[g] + m_st2[g]) * (m_p[g] + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        m_act[g] <= 1'b0; m_k[g] <= 0; m_sev[g] <= 4'd15;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (m_act[g]) begin
          if (m_k[g] + 1 == flen(g)) m_act[g] <= 1'b0;
          m_k[g] <= m_k[g] + 1;
        end else if (vld[g]) begin
          m_act[g] <= 1'b1; m_k[g] <= 0;
          m_p[g] <= int'(per); m_par[g] <= int'(par_en); m_st2[g] <= int'(st2);
          m_sev[g] <= per;
        end
      end
    end
  end

  // {rdy,crst,incr,wen,busy,done,sel}
  function automatic logic [7:0] model_out(input int g);
    int b, ph, pp, ds, nb;
    logic [1:0] s;
    logic inc, dn;
    if (!rst_n) return {6'b000000, 2'd1};
    if (!m_act[g]) return {1'b1, 1'b0, 1'b0, vld[g], 1'b0, 1'b0, 2'd1};
    ds = dsize(g);
    pp = m_p[g] + 1;
    b  = m_k[g] / pp;
    ph = m_k[g] % pp;
    nb = 2 + ds + m_par[g] + m_st2[g];
    if (b == 0) s = 2'd0;
    else if (b <= ds) s = 2'd2;
    else if (m_par[g] == 1 && b == ds + 1) s = 2'd3;
    else s = 2'd1;
    inc = (b >= 1) && (b <= ds) && (ph == pp - 1);
    dn  = (b == nb - 1) && (ph == pp - 1);
    return {1'b0, 1'b1, inc, 1'b0, 1'b1, dn, s};
  endfunction

  int checks = 0, failures = 0, cyc = 0;
  int acc_cyc [2], gap [2], done_rel [2], par_rel [2], stop_rel [2], incr_first [2], n_incr [2];

  task automatic chk(input int g, input logic [7:0] act, input logic [CW-1:0] sev_a);
    logic [7:0] e;
    e = model_out(g);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL outs%0d cyc=%0d {rdy,crst,incr,wen,busy,done,sel} actual=%b expected=%b", g, cyc, act, e);
    end
    checks++;
    if (sev_a !== m_sev[g]) begin
      failures++;
      $display("FAIL sev%0d cyc=%0d actual=%0d expected=%0d", g, cyc, sev_a, m_sev[g]);
    end
  endtask

  task automatic rec(input int g, input logic w, input logic d, input logic i, input logic [1:0] s, input logic bz);
    if (w) begin
      gap[g] = cyc - acc_cyc[g]; acc_cyc[g] = cyc;
      done_rel[g] = -1; par_rel[g] = -1; stop_rel[g] = -1; incr_first[g] = -1; n_incr[g] = 0;
    end
    if (i) begin
      if (incr_first[g] < 0) incr_first[g] = cyc - acc_cyc[g];
      n_incr[g]++;
    end
    if (bz && s == 2'd3 && par_rel[g] < 0) par_rel[g] = cyc - acc_cyc[g];
    if (bz && s == 2'd1 && stop_rel[g] < 0) stop_rel[g] = cyc - acc_cyc[g];
    if (d) done_rel[g] = cyc - acc_cyc[g];
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++; failures++;
    $display("FAIL timeout %s actual=expired expected=event", nm);
  endtask

  function automatic logic wen_of(input int g);
    return (g == 0) ? wen8 : wen5;
  endfunction

  function automatic logic done_of(input int g);
    return (g == 0) ? done8 : done5;
  endfunction

  task automatic send(input int g, input int p, input bit pe, input bit s2);
    int n;
    @(posedge clk); #1;
    per = CW'(p); par_en = pe; st2 = s2; vld[g] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wen_of(g) && n < 200);
    if (n >= 200) tmo("accept");
    @(posedge clk); #1;
    vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_of(g) && n < 3000);
    if (n >= 3000) tmo("tx_done");
    @(posedge clk); #1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      acc_cyc[g] = 0; gap[g] = 0; done_rel[g] = -1; par_rel[g] = -1;
      stop_rel[g] = -1; incr_first[g] = -1; n_incr[g] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        cyc++;
        chk(0, {rdy8, crst8, incr8, wen8, busy8, done8, sel8}, sev8);
        chk(1, {rdy5, crst5, incr5, wen5, busy5, done5, sel5}, sev5);
        rec(0, wen8, done8, incr8, sel8, busy8);
        rec(1, wen5, done5, incr5, sel5, busy5);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    lit("reset_select", int'(sel8), 1);
    lit("reset_sev", int'(sev8), 15);
    lit("reset_ready", int'(rdy8), 0);
    rst_n = 1'b1;

    // 8N1, bit_period 3
    send(0, 3, 1'b0, 1'b0);
    wait_done(0);
    lit("8n1_done", done_rel[0], 40);
    lit("8n1_first_incr", incr_first[0], 8);
    lit("8n1_n_incr", n_incr[0], 8);
    lit("8n1_stop_start", stop_rel[0], 37);
    lit("8n1_no_parity", par_rel[0], -1);
    lit("8n1_ready_after", int'(rdy8), 1);

    // 8E2, bit_period 3
    send(0, 3, 1'b1, 1'b1);
    wait_done(0);
    lit("8e2_parity", par_rel[0], 37);
    lit("8e2_stop_start", stop_rel[0], 41);
    lit("8e2_done", done_rel[0], 48);

    // 8N1, bit_period 0
    send(0, 0, 1'b0, 1'b0);
    wait_done(0);
    lit("p0_done", done_rel[0], 10);
    lit("p0_first_incr", incr_first[0], 2);
    lit("p0_n_incr", n_incr[0], 8);

    // Mid-frame config churn and a stray valid, then a valid held through tx_done.
    begin
      int n;
      send(0, 3, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1; per = 4'd9; par_en = 1'b1; st2 = 1'b1;
      repeat (5) @(posedge clk);
      #1; vld[0] = 1'b1;
      @(posedge clk);
      #1; vld[0] = 1'b0;
      repeat (15) @(posedge clk);
      #1; vld[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wen8 && n < 200);
      if (n >= 200) tmo("second_accept");
      @(posedge clk);
      #1; vld[0] = 1'b0;
      lit("back_to_back_gap", gap[0], 41);
      wait_done(0);
      lit("second_frame_done", done_rel[0], 120);
    end

    // Reset in the middle of DATA
    send(0, 3, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    lit("rst_select", int'(sel8), 1);
    lit("rst_cntr_rst", int'(crst8), 0);
    lit("rst_busy", int'(busy8), 0);
    lit("rst_sev", int'(sev8), 15);
    @(posedge clk);
    #1; rst_n = 1'b1;
    send(0, 2, 1'b0, 1'b0);
    wait_done(0);
    lit("post_rst_done", done_rel[0], 30);

    // 5O1 on the DATA_SIZE=5 instance, bit_period 1
    send(1, 1, 1'b1, 1'b0);
    wait_done(1);
    lit("5o1_first_incr", incr_first[1], 4);
    lit("5o1_n_incr", n_incr[1], 5);
    lit("5o1_parity", par_rel[1], 13);
    lit("5o1_stop_start", stop_rel[1], 15);
    lit("5o1_done", done_rel[1], 16);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      int g;
      g = int'($urandom_range(0, 1));
      send(g, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1; per = CW'($urandom); par_en = 1'($urandom); st2 = 1'($urandom);
        vld[g] = 1'b1;
        @(posedge clk);
        #1; vld[g] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2; rst_n = 1'b0;
        @(posedge clk);
        #1; rst_n = 1'b1;
      end else begin
        wait_done(g);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
